// File: rtl/drm_meter_pkg.sv
// Shared types and constants for the DRM metering gate and its activation-code comparator.
// Pure declarations: no logic, no latency, no flow control.
package drm_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } meter_state_e;

    localparam logic [127:0] DEF_EXP_ACT_CODE = 128'h8D7471B1462EF2B0159661F6A532861B;

    localparam int EVT_TOTAL_W = 32;
    localparam int EVT_DROP_W  = 16;
    localparam int LANE_W      = 32;
    localparam int N_LANES     = 128 / LANE_W;

    // Saturating increment for the dropped-event statistic.
    function automatic logic [EVT_DROP_W-1:0] sat_inc_drop(input logic [EVT_DROP_W-1:0] v);
        return (&v) ? v : v + EVT_DROP_W'(1);
    endfunction

endpackage

// File: rtl/act_code_cmp.sv
// Two-stage activation-code comparator: per-lane equality, then AND-reduce.
// Latency 2 cycles from activation_code to activated; no backpressure.
module act_code_cmp
    import drm_meter_pkg::*;
#(
    parameter logic [127:0] EXP_ACT_CODE = DEF_EXP_ACT_CODE
) (
    input  logic         clk,
    input  logic         areset,
    input  logic [127:0] activation_code,
    output logic         activated
);

    logic [N_LANES-1:0] lane_eq_d;
    logic [N_LANES-1:0] lane_eq_q;
    logic               activated_q;

    // Lanes are split so the 128-bit compare never sits in one timing path.
    always_comb begin
        lane_eq_d = '0;
        for (int i = 0; i < N_LANES; i++) begin
            lane_eq_d[i] = (activation_code[i*LANE_W +: LANE_W] == EXP_ACT_CODE[i*LANE_W +: LANE_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            lane_eq_q   <= '0;
            activated_q <= 1'b0;
        end else begin
            lane_eq_q   <= lane_eq_d;
            activated_q <= &lane_eq_q;
        end
    end

    assign activated = activated_q;

endmodule

// File: rtl/drm_metering_gate.sv
// Gates billable events on activation, buffers them, and replays them as spaced pulses.
// First pulse 2 cycles after an accepted event; pulses at least MIN_GAP+2 apart; overflow is counted, never stalls.
module drm_metering_gate
    import drm_meter_pkg::*;
#(
    parameter logic [127:0] EXP_ACT_CODE = DEF_EXP_ACT_CODE,
    parameter int           PEND_W       = 8,
    parameter int           MIN_GAP      = 4
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic [127:0]           activation_code,
    input  logic                   evt_in,
    input  logic                   clr_counters,
    output logic                   metering_event,
    output logic                   activated,
    output logic [PEND_W-1:0]      pending,
    output logic [EVT_TOTAL_W-1:0] evt_total,
    output logic [EVT_DROP_W-1:0]  evt_dropped
);

    localparam logic [7:0] GAP_RELOAD = 8'(MIN_GAP - 1);

    meter_state_e           state_q;
    logic [7:0]             gap_q;
    logic                   met_q;

    logic [PEND_W-1:0]      pend_q,  pend_d;
    logic [EVT_TOTAL_W-1:0] total_q, total_d;
    logic [EVT_DROP_W-1:0]  drop_q,  drop_d;

    logic                   inc;
    logic                   dec;
    logic                   pend_full;
    logic                   drop_evt;

    act_code_cmp #(
        .EXP_ACT_CODE (EXP_ACT_CODE)
    ) u_cmp (
        .clk             (clk),
        .areset          (areset),
        .activation_code (activation_code),
        .activated       (activated)
    );

    assign inc       = evt_in & activated;
    assign dec       = (state_q == ST_EMIT);
    assign pend_full = &pend_q;
    // A simultaneous dec frees a slot, so a full counter does not drop in that cycle.
    assign drop_evt  = inc & ~dec & pend_full;

    always_comb begin
        pend_d = pend_q;
        unique case ({inc, dec})
            2'b10:   pend_d = pend_full ? pend_q : pend_q + PEND_W'(1);
            2'b01:   pend_d = (pend_q != '0) ? pend_q - PEND_W'(1) : pend_q;
            default: pend_d = pend_q;
        endcase
    end

    always_comb begin
        total_d = total_q;
        drop_d  = drop_q;
        if (clr_counters) begin
            total_d = '0;
            drop_d  = '0;
        end else begin
            if (dec) begin
                total_d = total_q + EVT_TOTAL_W'(1);
            end
            if (drop_evt) begin
                drop_d = sat_inc_drop(drop_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            pend_q  <= '0;
            total_q <= '0;
            drop_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            total_q <= total_d;
            drop_q  <= drop_d;
        end
    end

    // Pulse scheduler; met_q is set on entry to EMIT so the pulse lines up with that state.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            met_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pend_q != '0) begin
                        state_q <= ST_EMIT;
                        met_q   <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    met_q   <= 1'b0;
                    gap_q   <= GAP_RELOAD;
                    state_q <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    met_q   <= 1'b0;
                end
            endcase
        end
    end

    assign metering_event = met_q;
    assign pending        = pend_q;
    assign evt_total      = total_q;
    assign evt_dropped    = drop_q;

endmodule

// File: doc/drm_metering_gate.md
Name: drm_metering_gate

Overview:
- Sits between the user IP's AXI4-Lite read path and the DRM activator's metering_event input.
- Drives metering_event and consumes the activator's 128-bit activation_code.
- Compares the activation code against the expected value through a 2-stage pipeline, accepts billable events only while activated, and buffers them in a saturating pending counter.
- Replays buffered events to the activator as rate-limited single-cycle pulses, and keeps emitted/dropped statistics for the register map.

Parameters:
- EXP_ACT_CODE, 128'h8D7471B1462EF2B0159661F6A532861B, expected activation code.
- PEND_W, 8, width of the pending-event counter; saturates at 2^PEND_W-1.
- MIN_GAP, 4, number of GAP cycles after each pulse; legal range 1..255.

Ports:
- clk  in  1  single clock for all logic.
- areset  in  1  synchronous, active-high reset.
- activation_code  in  128  code driven by the DRM activator.
- evt_in  in  1  one-cycle pulse per billable operation (read handshake accepted).
- clr_counters  in  1  one-cycle pulse; clears evt_total and evt_dropped.
- metering_event  out  1  registered single-cycle pulse to the DRM activator.
- activated  out  1  registered; 1 when code equals EXP_ACT_CODE.
- pending  out  PEND_W  events accepted but not yet emitted.
- evt_total  out  32  emitted pulse count; wraps modulo 2^32.
- evt_dropped  out  16  events lost to saturation; saturates at 16'hFFFF.

Behaviour:
- Reset: on a clk edge with areset=1, every output and every internal register goes to 0 and the FSM goes to IDLE.
- Reset mid-drain: pending events are discarded; metering_event is 0 in the cycle after reset asserts.
- Activation compare, stage 1: register lane_eq[3:0], one bit per 32-bit lane of activation_code versus EXP_ACT_CODE.
- Activation compare, stage 2: activated <= &lane_eq.
- Compare latency: a code change is reflected on activated exactly 2 cycles later. An all-zero code never matches, because EXP_ACT_CODE is nonzero.
- Accept: evt_in=1 with activated=1 in the same cycle gives inc=1. evt_in while activated=0 is ignored and not counted anywhere.
- Saturation: inc with pending at all-ones and no dec in that cycle leaves pending unchanged; evt_dropped += 1 unless it is already 16'hFFFF.
- Pending update: inc only gives +1; dec only gives -1; inc and dec in the same cycle leave pending unchanged. An inc into a full counter with a simultaneous dec is not a drop.
- Deactivation: events already pending keep draining while activated=0; only new acceptance stops.
- FSM states: IDLE, EMIT, GAP.
  - IDLE: if pending != 0, go to EMIT; else stay in IDLE.
  - EMIT (exactly 1 cycle): metering_event=1, dec=1, evt_total += 1, gap_cnt <= MIN_GAP-1, go to GAP.
  - GAP: if gap_cnt == 0, go to IDLE; else gap_cnt -= 1.
- Pulse timing: metering_event is a registered output, asserted in the cycle the FSM is in EMIT.
  - The first pulse occurs 2 cycles after the accepting evt_in cycle (pending updates, then IDLE→EMIT).
  - Back-to-back pulses are spaced exactly MIN_GAP+2 cycles apart.
- clr_counters: zeroes evt_total and evt_dropped on the next edge. If a clear coincides with an increment, the clear wins and the value is 0. pending is not affected.
- Width rules: all counters are unsigned. evt_total wraps from 32'hFFFFFFFF to 0. evt_dropped saturates. pending never wraps in either direction.

Decomposition:
- Package drm_meter_pkg holds:
  - the FSM state typedef (IDLE, EMIT, GAP; 2 bits);
  - the default EXP_ACT_CODE constant;
  - the constants EVT_TOTAL_W=32 and EVT_DROP_W=16.
- Sub-module act_code_cmp: 2-stage lane comparator.
  - Parameter: EXP_ACT_CODE.
  - Ports: clk, areset, activation_code, activated.
  - Used here; reusable by other user IPs.

Test Plan:
- Activation and single pulse:
  - Stimulus: reset, then drive activation_code=EXP_ACT_CODE at cycle 0.
  - Required: activated=1 at cycle 2.
  - Then a single evt_in at cycle 5 → pending=1 at cycle 6, metering_event at cycle 7, evt_total=1, pending=0.
- Blocked while inactive:
  - Stimulus: activation_code=128'h1, pulse evt_in 10 times.
  - Required: activated stays 0, pending=0, evt_total=0, metering_event never asserts.
- Burst and saturation:
  - Stimulus: PEND_W=4, MIN_GAP=4, activated, evt_in held high for 20 cycles.
  - Required: pending peaks at 15, evt_dropped>0 (exact count checked against a model), pulses spaced 6 cycles apart.
  - After the burst, pending drains to 0 and evt_total+evt_dropped=20.
- Simultaneous inc/dec and deactivation:
  - Stimulus: pending=3, evt_in coincides with an EMIT cycle.
  - Required: pending stays 3 for that cycle.
  - Then set activation_code=0: activated=0 two cycles later, and the remaining 3 events still emit.
- Counter clear and wrap:
  - Stimulus: force evt_total=32'hFFFFFFFF and emit one pulse.
  - Required: evt_total=0.
  - A clr_counters pulse coinciding with an EMIT → evt_total=0 and evt_dropped=0 on the next cycle.
- Reset mid-drain:
  - Stimulus: pending=5, assert areset for 1 cycle during GAP.
  - Required: all outputs 0 the next cycle, FSM in IDLE, no further pulses until new accepted events.
